// File: rtl/mmu_skew_feeder.sv
// Input-side feeder for the MMU systolic array: buffers one tile of (data, weight)
// beats, then replays it with per-lane diagonal skew, a zero drain window and a done pulse.
module mmu_skew_feeder #(
    parameter int unsigned depth     = 4,
    parameter int unsigned bit_width = 8,
    parameter int unsigned drain_cyc = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [bit_width*depth-1:0]   in_data,
    input  logic [bit_width*depth-1:0]   in_wt,
    output logic [bit_width*depth-1:0]   data_arr,
    output logic [bit_width*depth-1:0]   wt_arr,
    output logic                         control,
    output logic                         busy,
    output logic                         tile_done
);

    localparam int unsigned VW = bit_width * depth;
    localparam int unsigned BW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned FW = $clog2(2 * depth);
    localparam int unsigned DW = (drain_cyc > 1) ? $clog2(drain_cyc) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [FW-1:0]   feed_q, feed_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic [VW-1:0]   d_buf_q [depth];
    logic [VW-1:0]   d_buf_d [depth];
    logic [VW-1:0]   w_buf_q [depth];
    logic [VW-1:0]   w_buf_d [depth];

    logic [VW-1:0]   data_arr_q, data_arr_d;
    logic [VW-1:0]   wt_arr_q, wt_arr_d;
    logic            control_q, control_d;
    logic            busy_q, busy_d;
    logic            tile_done_q, tile_done_d;

    // Lane i at feed cycle t carries lane i of beat t-i; out-of-window slots are zero.
    function automatic logic [VW-1:0] skew(input logic [VW-1:0] buf_v [depth],
                                           input int unsigned t);
        logic [VW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            if (t >= i && (t - i) < depth) begin
                v[bit_width*i +: bit_width] = buf_v[BW'(t - i)][bit_width*i +: bit_width];
            end
        end
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        feed_d      = feed_q;
        drain_d     = drain_q;
        d_buf_d     = d_buf_q;
        w_buf_d     = w_buf_q;
        data_arr_d  = '0;
        wt_arr_d    = '0;
        control_d   = 1'b0;
        busy_d      = 1'b0;
        tile_done_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    d_buf_d[beat_q] = in_data;
                    w_buf_d[beat_q] = in_wt;
                    if (beat_q == BW'(depth - 1)) begin
                        // Skew reads the _d buffer so the beat written on this edge is visible at t=0.
                        state_d    = FEED;
                        beat_d     = '0;
                        feed_d     = '0;
                        control_d  = 1'b1;
                        busy_d     = 1'b1;
                        data_arr_d = skew(d_buf_d, 0);
                        wt_arr_d   = skew(w_buf_d, 0);
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FEED: begin
                control_d = 1'b1;
                busy_d    = 1'b1;
                if (feed_q == FW'(2 * depth - 2)) begin
                    state_d     = DRAIN;
                    drain_d     = '0;
                    tile_done_d = (drain_cyc == 1);
                end else begin
                    feed_d     = feed_q + 1'b1;
                    data_arr_d = skew(d_buf_d, int'(feed_q) + 1);
                    wt_arr_d   = skew(w_buf_d, int'(feed_q) + 1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(drain_cyc - 1)) begin
                    state_d = LOAD;
                    drain_d = '0;
                end else begin
                    drain_d     = drain_q + 1'b1;
                    control_d   = 1'b1;
                    busy_d      = 1'b1;
                    tile_done_d = (drain_q == DW'(drain_cyc - 2));
                end
            end
            default: begin
                state_d = LOAD;
                beat_d  = '0;
                feed_d  = '0;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            beat_q      <= '0;
            feed_q      <= '0;
            drain_q     <= '0;
            data_arr_q  <= '0;
            wt_arr_q    <= '0;
            control_q   <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            feed_q      <= feed_d;
            drain_q     <= drain_d;
            data_arr_q  <= data_arr_d;
            wt_arr_q    <= wt_arr_d;
            control_q   <= control_d;
            busy_q      <= busy_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Tile buffer is always fully rewritten before use, so it carries no reset.
    always_ff @(posedge clk) begin
        d_buf_q <= d_buf_d;
        w_buf_q <= w_buf_d;
    end

    assign in_ready  = (state_q == LOAD) && !reset;
    assign data_arr  = data_arr_q;
    assign wt_arr    = wt_arr_q;
    assign control   = control_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;

endmodule
